// File: rtl/hbridge_drive_ctrl_if.sv
// ---------------------------------------------------------------------------
// hbridge_drive_ctrl_if
// Groups the motor-command inputs and H-bridge pin outputs of the
// multi-channel H-bridge driver into one bundle.
//
// Signals (widths set by NUM_CH / PWM_W):
//   enable      [NUM_CH]        per-channel drive enable
//   direction   [NUM_CH]        1 = forward, 0 = reverse
//   brake       [NUM_CH]        per-channel brake request, highest priority
//   duty        [NUM_CH*PWM_W]  per-channel duty, ch k = duty[k*PWM_W +: PWM_W]
//   in_a        [NUM_CH]        H-bridge input A per channel
//   in_b        [NUM_CH]        H-bridge input B per channel
//   dead_active [NUM_CH]        high while a channel sits in its dead-time state
//   pwm_wrap    [1]             one-cycle pulse when the shared PWM counter is 0
//
// Modports:
//   master : motor-command side, drives commands and observes the pins
//   slave  : the driver itself
// ---------------------------------------------------------------------------
interface hbridge_drive_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int PWM_W  = 8
);

  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH-1:0]       direction;
  logic [NUM_CH-1:0]       brake;
  logic [NUM_CH*PWM_W-1:0] duty;
  logic [NUM_CH-1:0]       in_a;
  logic [NUM_CH-1:0]       in_b;
  logic [NUM_CH-1:0]       dead_active;
  logic                    pwm_wrap;

  modport master (
    output enable, direction, brake, duty,
    input  in_a, in_b, dead_active, pwm_wrap
  );

  modport slave (
    input  enable, direction, brake, duty,
    output in_a, in_b, dead_active, pwm_wrap
  );

endinterface

// File: rtl/hbridge_drive_ctrl.sv
// ---------------------------------------------------------------------------
// hbridge_drive_ctrl
// Multi-channel H-bridge driver. For every motor channel it turns the
// enable/direction/brake/duty commands into PWM gate inputs IN_A/IN_B,
// inserting a dead-time window on every reversal and on every brake release
// so the two bridge legs never conduct in overlapping windows. Duty values
// are only picked up at the end of a PWM period, so a period is never
// chopped by a mid-period update.
//
// Parameters:
//   NUM_CH        number of motor channels
//   PWM_W         PWM counter / duty width, period = 2**PWM_W clocks
//   DEADTIME_CYC  cycles both pins are held low around a leg change (>= 1)
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   driveBus  hbridge_drive_ctrl_if.slave
//               in : enable, direction, brake, duty
//               out: in_a, in_b, dead_active, pwm_wrap
//
// Configuration macro:
//   BRAKE_ACTIVE_EN  undefined -> coast brake (both pins low while braking)
//                    defined   -> active short-brake: after DEADTIME_CYC
//                                 cycles of braking both pins are driven high
// ---------------------------------------------------------------------------
module hbridge_drive_ctrl #(
  parameter int NUM_CH       = 2,
  parameter int PWM_W        = 8,
  parameter int DEADTIME_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  hbridge_drive_ctrl_if.slave driveBus
);

  localparam int DC_W = $clog2(DEADTIME_CYC + 1);
  localparam logic [PWM_W-1:0] CNT_MAX   = {PWM_W{1'b1}};
  localparam logic [DC_W-1:0]  DEAD_LAST = DC_W'(DEADTIME_CYC - 1);
  localparam logic [DC_W-1:0]  DEAD_FULL = DC_W'(DEADTIME_CYC);

  typedef enum logic [2:0] {
    S_OFF,
    S_FWD,
    S_REV,
    S_DEAD,
    S_BRAKE
  } chState_e;

  logic [PWM_W-1:0] pwmCnt_q;
  logic [PWM_W-1:0] pwmCnt_d;
  logic             pwmWrap_q;
  logic             pwmWrap_d;

  // The shared PWM counter simply free-runs. The wrap flag is computed from
  // the value about to roll over so that, once registered, it is high in
  // exactly the cycle the counter reads 0, yet stays low straight out of reset.
  always_comb begin
    pwmCnt_d  = pwmCnt_q + 1'b1;
    pwmWrap_d = (pwmCnt_q == CNT_MAX);
  end

  // Counter and wrap pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwmCnt_q  <= '0;
      pwmWrap_q <= 1'b0;
    end else begin
      pwmCnt_q  <= pwmCnt_d;
      pwmWrap_q <= pwmWrap_d;
    end
  end

  assign driveBus.pwm_wrap = pwmWrap_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch

    chState_e         state_q;
    chState_e         state_d;
    logic [DC_W-1:0]  deadCnt_q;
    logic [DC_W-1:0]  deadCnt_d;
    logic             viaBrake_q;
    logic             viaBrake_d;
    logic [PWM_W-1:0] duty_q;
    logic [PWM_W-1:0] duty_d;
    logic             inA_q;
    logic             inA_d;
    logic             inB_q;
    logic             inB_d;
    logic             pwmOn;
    logic             deadExpired;
    logic             brakeHeld;
    logic             enI;
    logic             dirI;
    logic             brkI;
    logic [PWM_W-1:0] dutyI;

    assign enI   = driveBus.enable[k];
    assign dirI  = driveBus.direction[k];
    assign brkI  = driveBus.brake[k];
    assign dutyI = driveBus.duty[k*PWM_W +: PWM_W];

    assign pwmOn       = (pwmCnt_q < duty_q);
    assign deadExpired = (deadCnt_q == DEAD_LAST);
    assign brakeHeld   = (deadCnt_q == DEAD_FULL);

    // A new duty is only accepted on the last count of a period, so the
    // compare value is constant across every full period.
    always_comb begin
      duty_d = duty_q;
      if (pwmCnt_q == CNT_MAX) begin
        duty_d = dutyI;
      end
    end

    // Channel state machine. Brake overrides everything, then a dropped
    // enable, then direction. A dead window entered from a brake release is
    // always served to completion even with enable low, because under the
    // active brake both legs were just on. A dead window entered from a
    // reversal can be abandoned straight to OFF when enable drops.
    // The cycle counter restarts on every state change and saturates at
    // DEADTIME_CYC; it times both the dead window and the brake hold.
    // Pin values are derived from the current state and registered, giving
    // one cycle of latency from state to pins.
    always_comb begin
      state_d    = state_q;
      deadCnt_d  = deadCnt_q;
      viaBrake_d = viaBrake_q;
      inA_d      = 1'b0;
      inB_d      = 1'b0;

      if (brkI) begin
        state_d = S_BRAKE;
      end else begin
        case (state_q)
          S_OFF: begin
            if (enI) begin
              state_d = dirI ? S_FWD : S_REV;
            end
          end
          S_FWD: begin
            if (!enI) begin
              state_d = S_OFF;
            end else if (!dirI) begin
              state_d = S_DEAD;
            end
          end
          S_REV: begin
            if (!enI) begin
              state_d = S_OFF;
            end else if (dirI) begin
              state_d = S_DEAD;
            end
          end
          S_DEAD: begin
            if (!enI && !viaBrake_q) begin
              state_d = S_OFF;
            end else if (deadExpired) begin
              if (!enI) begin
                state_d = S_OFF;
              end else begin
                state_d = dirI ? S_FWD : S_REV;
              end
            end
          end
          S_BRAKE: begin
            state_d = S_DEAD;
          end
          default: begin
            state_d = S_OFF;
          end
        endcase
      end

      if (state_d != state_q) begin
        deadCnt_d = '0;
      end else if (deadCnt_q != DEAD_FULL) begin
        deadCnt_d = deadCnt_q + 1'b1;
      end

      if ((state_d == S_DEAD) && (state_q != S_DEAD)) begin
        viaBrake_d = (state_q == S_BRAKE);
      end

      case (state_q)
        S_FWD: begin
          inA_d = pwmOn;
        end
        S_REV: begin
          inB_d = pwmOn;
        end
        S_BRAKE: begin
`ifdef BRAKE_ACTIVE_EN
          inA_d = brakeHeld;
          inB_d = brakeHeld;
`else
          inA_d = 1'b0;
          inB_d = 1'b0;
`endif
        end
        default: begin
          inA_d = 1'b0;
          inB_d = 1'b0;
        end
      endcase
    end

    // Per-channel state, timer, latched duty and registered pins. Reset
    // drops the pins on the very next edge regardless of state or count.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q    <= S_OFF;
        deadCnt_q  <= '0;
        viaBrake_q <= 1'b0;
        duty_q     <= '0;
        inA_q      <= 1'b0;
        inB_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        deadCnt_q  <= deadCnt_d;
        viaBrake_q <= viaBrake_d;
        duty_q     <= duty_d;
        inA_q      <= inA_d;
        inB_q      <= inB_d;
      end
    end

    assign driveBus.in_a[k]        = inA_q;
    assign driveBus.in_b[k]        = inB_q;
    assign driveBus.dead_active[k] = (state_q == S_DEAD);

  end

endmodule
